// File: rtl/proc_pkg.sv
// Shared types and constants for the vectored interrupt controller.
package proc_pkg;

    typedef enum logic [1:0] {
        IRQ_IDLE,
        IRQ_REQ,
        IRQ_SERVICE
    } irq_state_t;

    localparam logic [1:0] CFG_SEL_ENABLE = 2'd0;
    localparam logic [1:0] CFG_SEL_MODE   = 2'd1;
    localparam logic [1:0] CFG_SEL_W1C    = 2'd2;
    localparam logic [1:0] CFG_SEL_GLOBAL = 2'd3;

    localparam logic [31:0] VEC_BASE_DEFAULT   = 32'h0000_0100;
    localparam int          VEC_STRIDE_DEFAULT = 4;

endpackage

// File: rtl/irq_sync_edge.sv
// Two-flop synchroniser for one asynchronous interrupt line plus rising-edge pulse.
module irq_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic irq,
    output logic level,
    output logic rise
);

    logic s1, s2, s2_d;

    always_ff @(posedge clk) begin
        if (!rst) begin
            s1   <= 1'b0;
            s2   <= 1'b0;
            s2_d <= 1'b0;
        end else begin
            s1   <= irq;
            s2   <= s1;
            s2_d <= s2;
        end
    end

    assign level = s2;
    assign rise  = s2 & ~s2_d;

endmodule

// File: rtl/irq_vector_ctrl.sv
// Multi-source vectored interrupt controller: sync, pending/enable state,
// fixed-priority arbitration and req/ack/mret handshake with the hazard unit.
module irq_vector_ctrl
    import proc_pkg::*;
#(
    parameter int          NUM_SRC    = 8,
    parameter logic [31:0] VEC_BASE   = VEC_BASE_DEFAULT,
    parameter int          VEC_STRIDE = VEC_STRIDE_DEFAULT,
    parameter int          ID_W       = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_SRC-1:0] irq_in,
    input  logic               cfg_we,
    input  logic [1:0]         cfg_sel,
    input  logic [NUM_SRC-1:0] cfg_wdata,
    input  logic               int_ack,
    input  logic [31:0]        epc_in,
    input  logic               mret,
    output logic               int_req,
    output logic [31:0]        int_addr,
    output logic [ID_W-1:0]    int_id,
    output logic               in_service,
    output logic [31:0]        epc_out,
    output logic [NUM_SRC-1:0] enable_q,
    output logic [NUM_SRC-1:0] pending_q
);

    irq_state_t         state, state_nxt;
    logic [NUM_SRC-1:0] level, rise, mode_q, w1c, ack_clr, pending_nxt, cand;
    logic               global_en, cand_vld, take_ack;
    logic [ID_W-1:0]    cand_id;

    for (genvar g = 0; g < NUM_SRC; g++) begin : g_sync
        irq_sync_edge u_sync (
            .clk   (clk),
            .rst   (rst),
            .irq   (irq_in[g]),
            .level (level[g]),
            .rise  (rise[g])
        );
    end

    assign take_ack = (state == IRQ_REQ) && int_ack;

    // Edge sources: clears (ack, W1C) applied before the new edge so a
    // coincident edge keeps the bit set. Level sources simply track the line.
    always_comb begin
        w1c     = (cfg_we && cfg_sel == CFG_SEL_W1C) ? cfg_wdata : '0;
        ack_clr = '0;
        for (int i = 0; i < NUM_SRC; i++)
            ack_clr[i] = take_ack && (ID_W'(i) == int_id);
        pending_nxt = (mode_q & ((pending_q & ~ack_clr & ~w1c) | rise))
                    | (~mode_q & level);
    end

    assign cand = pending_q & enable_q & {NUM_SRC{global_en}};

    always_comb begin
        cand_vld = |cand;
        cand_id  = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--)
            if (cand[i]) cand_id = ID_W'(i);
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IRQ_IDLE:    if (cand_vld) state_nxt = IRQ_REQ;
            IRQ_REQ:     if (int_ack)  state_nxt = IRQ_SERVICE;
            IRQ_SERVICE: if (mret)     state_nxt = IRQ_IDLE;
            default:                   state_nxt = IRQ_IDLE;
        endcase
    end

    always_comb begin
        int_req    = (state == IRQ_REQ);
        in_service = (state == IRQ_SERVICE);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IRQ_IDLE;
            int_id    <= '0;
            int_addr  <= '0;
            epc_out   <= '0;
            enable_q  <= '0;
            mode_q    <= '0;
            pending_q <= '0;
            global_en <= 1'b0;
        end else begin
            state     <= state_nxt;
            pending_q <= pending_nxt;
            if (state == IRQ_IDLE && cand_vld) begin
                int_id   <= cand_id;
                int_addr <= VEC_BASE + 32'(cand_id) * 32'(VEC_STRIDE);
            end
            if (take_ack)
                epc_out <= epc_in;
            if (cfg_we) begin
                case (cfg_sel)
                    CFG_SEL_ENABLE: enable_q  <= cfg_wdata;
                    CFG_SEL_MODE:   mode_q    <= cfg_wdata;
                    CFG_SEL_GLOBAL: global_en <= cfg_wdata[0];
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_irq_vector_ctrl.sv
// Scoreboarded bench for irq_vector_ctrl: expected vectors queued at stimulus,
// checked when int_req appears.
module tb_irq_vector_ctrl;
    import proc_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  irq_in;
    logic        cfg_we;
    logic [1:0]  cfg_sel;
    logic [7:0]  cfg_wdata;
    logic        int_ack;
    logic [31:0] epc_in;
    logic        mret;
    logic        int_req;
    logic [31:0] int_addr;
    logic [2:0]  int_id;
    logic        in_service;
    logic [31:0] epc_out;
    logic [7:0]  enable_q;
    logic [7:0]  pending_q;

    typedef struct packed {
        logic [2:0]  id;
        logic [31:0] addr;
    } exp_t;

    exp_t exp_q[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    irq_vector_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .irq_in     (irq_in),
        .cfg_we     (cfg_we),
        .cfg_sel    (cfg_sel),
        .cfg_wdata  (cfg_wdata),
        .int_ack    (int_ack),
        .epc_in     (epc_in),
        .mret       (mret),
        .int_req    (int_req),
        .int_addr   (int_addr),
        .int_id     (int_id),
        .in_service (in_service),
        .epc_out    (epc_out),
        .enable_q   (enable_q),
        .pending_q  (pending_q)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg(input logic [1:0] sel, input logic [7:0] data);
        cfg_we = 1'b1; cfg_sel = sel; cfg_wdata = data;
        tick();
        cfg_we = 1'b0;
    endtask

    task automatic wait_req(input string tag);
        int n = 0;
        while (!int_req && n < 20) begin
            tick();
            n++;
        end
        chk({tag, "_req"}, 32'(int_req), 32'd1);
    endtask

    task automatic sb_pop(input string tag);
        exp_t e;
        if (exp_q.size() == 0) begin
            chk({tag, "_sb_size"}, 32'(exp_q.size()), 32'd1);
        end else begin
            e = exp_q.pop_front();
            chk({tag, "_id"}, 32'(int_id), 32'(e.id));
            chk({tag, "_addr"}, int_addr, e.addr);
        end
    endtask

    task automatic ack(input string tag, input logic [31:0] epc);
        epc_in = epc; int_ack = 1'b1;
        tick();
        int_ack = 1'b0;
        chk({tag, "_ack_req"}, 32'(int_req), 32'd0);
        chk({tag, "_ack_svc"}, 32'(in_service), 32'd1);
        chk({tag, "_epc"}, epc_out, epc);
    endtask

    task automatic ret(input string tag);
        mret = 1'b1;
        tick();
        mret = 1'b0;
        chk({tag, "_ret_svc"}, 32'(in_service), 32'd0);
    endtask

    initial begin
        int bad;
        rst = 1'b0; irq_in = '0; cfg_we = 1'b0; cfg_sel = '0; cfg_wdata = '0;
        int_ack = 1'b0; epc_in = '0; mret = 1'b0;
        tick(); tick();
        chk("rst_req", 32'(int_req), 32'd0);
        chk("rst_svc", 32'(in_service), 32'd0);
        chk("rst_addr", int_addr, 32'd0);
        chk("rst_pend", 32'(pending_q), 32'd0);
        rst = 1'b1;

        // 1: single edge source, exact latency
        cfg(CFG_SEL_ENABLE, 8'h04);
        cfg(CFG_SEL_MODE, 8'h04);
        cfg(CFG_SEL_GLOBAL, 8'h01);
        irq_in[2] = 1'b1;
        exp_q.push_back('{3'd2, 32'h108});
        tick();                               // E0
        irq_in[2] = 1'b0;
        tick();                               // E1
        chk("t1_pend_e1", 32'(pending_q[2]), 32'd0);
        tick();                               // E2
        chk("t1_pend_e2", 32'(pending_q[2]), 32'd1);
        chk("t1_req_e2", 32'(int_req), 32'd0);
        tick();                               // E3
        chk("t1_req_e3", 32'(int_req), 32'd1);
        sb_pop("t1");
        ack("t1", 32'h10);
        chk("t1_pend_clr", 32'(pending_q[2]), 32'd0);
        ret("t1");

        // 2: simultaneous rises, lowest index first
        cfg(CFG_SEL_ENABLE, 8'h22);
        cfg(CFG_SEL_MODE, 8'h22);
        irq_in[5] = 1'b1; irq_in[1] = 1'b1;
        exp_q.push_back('{3'd1, 32'h104});
        tick();
        irq_in[5] = 1'b0; irq_in[1] = 1'b0;
        wait_req("t2a");
        sb_pop("t2a");
        ack("t2a", 32'h20);
        exp_q.push_back('{3'd5, 32'h114});
        ret("t2a");
        chk("t2_gap_req", 32'(int_req), 32'd0);
        wait_req("t2b");
        sb_pop("t2b");
        ack("t2b", 32'h24);
        ret("t2b");

        // 3: REQ held stable while source is disabled
        cfg(CFG_SEL_ENABLE, 8'h10);
        cfg(CFG_SEL_MODE, 8'h10);
        irq_in[4] = 1'b1;
        exp_q.push_back('{3'd4, 32'h110});
        tick();
        irq_in[4] = 1'b0;
        wait_req("t3");
        sb_pop("t3");
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            if (i == 3) cfg(CFG_SEL_ENABLE, 8'h00);
            else tick();
            if (!int_req || int_addr != 32'h110 || int_id != 3'd4) bad++;
        end
        chk("t3_stable", 32'(bad), 32'd0);
        chk("t3_enable_rb", 32'(enable_q), 32'd0);
        ack("t3", 32'h40);
        ret("t3");

        // disabled source still records pending; request follows enable
        cfg(CFG_SEL_MODE, 8'h01);
        irq_in[0] = 1'b1;
        tick();
        irq_in[0] = 1'b0;
        repeat (4) tick();
        chk("dis_pend", 32'(pending_q[0]), 32'd1);
        chk("dis_req", 32'(int_req), 32'd0);
        exp_q.push_back('{3'd0, 32'h100});
        cfg(CFG_SEL_ENABLE, 8'h01);
        wait_req("dis");
        sb_pop("dis");
        ack("dis", 32'h50);
        ret("dis");

        // 4: new edge coincident with ack keeps pending set
        cfg(CFG_SEL_ENABLE, 8'h40);
        cfg(CFG_SEL_MODE, 8'h40);
        irq_in[6] = 1'b1;
        exp_q.push_back('{3'd6, 32'h118});
        tick();
        irq_in[6] = 1'b0;
        wait_req("t4a");
        sb_pop("t4a");
        repeat (3) tick();
        irq_in[6] = 1'b1;
        tick(); tick();
        ack("t4a", 32'h80);
        irq_in[6] = 1'b0;
        chk("t4_pend_kept", 32'(pending_q[6]), 32'd1);
        exp_q.push_back('{3'd6, 32'h118});
        ret("t4a");
        wait_req("t4b");
        sb_pop("t4b");
        ack("t4b", 32'h84);
        ret("t4b");

        // 5: level source re-request / drop
        cfg(CFG_SEL_MODE, 8'h00);
        cfg(CFG_SEL_ENABLE, 8'h08);
        irq_in[3] = 1'b1;
        exp_q.push_back('{3'd3, 32'h10C});
        wait_req("t5a");
        sb_pop("t5a");
        ack("t5a", 32'h90);
        chk("t5_level_pend", 32'(pending_q[3]), 32'd1);
        ret("t5a");
        chk("t5_idle_req", 32'(int_req), 32'd0);
        exp_q.push_back('{3'd3, 32'h10C});
        tick();
        chk("t5_rereq", 32'(int_req), 32'd1);
        sb_pop("t5b");
        ack("t5b", 32'h94);
        irq_in[3] = 1'b0;
        repeat (4) tick();
        chk("t5_pend_drop", 32'(pending_q[3]), 32'd0);
        ret("t5b");
        repeat (3) tick();
        chk("t5_no_req", 32'(int_req), 32'd0);

        // 6: reset during SERVICE
        irq_in[3] = 1'b1;
        exp_q.push_back('{3'd3, 32'h10C});
        wait_req("t6");
        sb_pop("t6");
        ack("t6", 32'h99);
        rst = 1'b0;
        tick();
        chk("t6_req", 32'(int_req), 32'd0);
        chk("t6_svc", 32'(in_service), 32'd0);
        chk("t6_epc", epc_out, 32'd0);
        chk("t6_addr", int_addr, 32'd0);
        chk("t6_id", 32'(int_id), 32'd0);
        chk("t6_en", 32'(enable_q), 32'd0);
        chk("t6_pend", 32'(pending_q), 32'd0);
        rst = 1'b1;
        mret = 1'b1;
        tick();
        mret = 1'b0;
        repeat (3) tick();
        chk("t6_mret_svc", 32'(in_service), 32'd0);
        chk("t6_mret_req", 32'(int_req), 32'd0);
        irq_in = '0;

        chk("sb_drain", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
